// File: rtl/midi_pkg.sv
// Shared MIDI transmit definitions: status nibbles, message-type encodings,
// serial timing constants and small decode helpers.
package midi_pkg;

  localparam int unsigned CLK_HZ               = 25_000_000;
  localparam int unsigned BAUD                 = 31_250;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = CLK_HZ / BAUD;

  localparam logic [3:0] NOTE_OFF       = 4'h8;
  localparam logic [3:0] NOTE_ON        = 4'h9;
  localparam logic [3:0] CONTROL_CHANGE = 4'hB;
  localparam logic [3:0] PROGRAM_CHANGE = 4'hC;

  typedef enum logic [1:0] {
    MSG_NOTE_OFF       = 2'd0,
    MSG_NOTE_ON        = 2'd1,
    MSG_CONTROL_CHANGE = 2'd2,
    MSG_PROGRAM_CHANGE = 2'd3
  } msg_type_t;

  function automatic logic [3:0] status_nibble(input msg_type_t t);
    case (t)
      MSG_NOTE_OFF:       return NOTE_OFF;
      MSG_NOTE_ON:        return NOTE_ON;
      MSG_CONTROL_CHANGE: return CONTROL_CHANGE;
      default:            return PROGRAM_CHANGE;
    endcase
  endfunction

  // Full message length including the status byte.
  function automatic logic [1:0] byte_count(input msg_type_t t);
    return (t == MSG_PROGRAM_CHANGE) ? 2'd2 : 2'd3;
  endfunction

endpackage

// File: rtl/midi_transmitter_uart_tx_byte.sv
// uart_tx_byte: 8N1 byte serializer, LSB first.
//   clk, reset         : system clock, async active-high reset
//   tx_valid/tx_ready  : byte handshake; tx_ready is also high on the last
//                        clock of a stop bit so bytes can follow gaplessly
//   tx_data            : byte to send
//   byte_done          : pulses on the last clock of each stop bit
//   tx                 : serial line, idle high
module uart_tx_byte
  import midi_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  output logic       byte_done,
  output logic       tx
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  tx_state_t        state, state_nx;
  logic [CNT_W-1:0] baud_cnt, baud_cnt_nx;
  logic [2:0]       bit_idx, bit_idx_nx;
  logic [7:0]       shreg, shreg_nx;
  logic             tx_nx;
  logic             bit_end;

  assign bit_end = (baud_cnt == CNT_LAST);

  always_comb begin
    state_nx    = state;
    baud_cnt_nx = baud_cnt;
    bit_idx_nx  = bit_idx;
    shreg_nx    = shreg;
    tx_nx       = tx;
    tx_ready    = 1'b0;
    byte_done   = 1'b0;

    if (state != TX_IDLE) begin
      baud_cnt_nx = bit_end ? '0 : baud_cnt + 1'b1;
    end

    case (state)
      TX_IDLE: begin
        tx_ready = 1'b1;
        if (tx_valid) begin
          shreg_nx    = tx_data;
          baud_cnt_nx = '0;
          state_nx    = TX_START;
          tx_nx       = 1'b0;
        end
      end
      TX_START: begin
        if (bit_end) begin
          state_nx   = TX_DATA;
          bit_idx_nx = '0;
          tx_nx      = shreg[0];
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
            state_nx = TX_STOP;
            tx_nx    = 1'b1;
          end else begin
            bit_idx_nx = bit_idx + 3'd1;
            shreg_nx   = shreg >> 1;
            tx_nx      = shreg[1];
          end
        end
      end
      default: begin // TX_STOP
        if (bit_end) begin
          byte_done = 1'b1;
          tx_ready  = 1'b1;
          if (tx_valid) begin
            shreg_nx = tx_data;
            state_nx = TX_START;
            tx_nx    = 1'b0;
          end else begin
            state_nx = TX_IDLE;
            tx_nx    = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= TX_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_nx;
      baud_cnt <= baud_cnt_nx;
      bit_idx  <= bit_idx_nx;
      shreg    <= shreg_nx;
      tx       <= tx_nx;
    end
  end

endmodule

// File: rtl/midi_transmitter.sv
// midi_transmitter: serializes MIDI channel-voice messages onto a 31250-baud
// 8N1 MIDI OUT line, with optional running-status compression.
//   clk, reset          : 25 MHz system clock, async active-high reset
//   msg_valid/msg_ready : one message per handshake
//   msg_type, channel   : message kind and MIDI channel
//   data1, data2        : data bytes (bit 7 masked; data2 unused for type 3)
//   midi_out            : serial line, idle high
//   busy                : high from first start bit to end of last stop bit
module midi_transmitter
  import midi_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT   = DEFAULT_CLKS_PER_BIT,
  parameter bit          RUNNING_STATUS = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       msg_valid,
  output logic       msg_ready,
  input  logic [1:0] msg_type,
  input  logic [3:0] channel,
  input  logic [7:0] data1,
  input  logic [7:0] data2,
  output logic       midi_out,
  output logic       busy
);

  // DONE is the single post-message cycle; it already accepts a new message
  // so back-to-back messages lose no extra cycle.
  typedef enum logic [1:0] {IDLE, SEND, DONE} msg_state_t;

  msg_state_t state, state_nx;
  logic [1:0] byte_idx, byte_cnt;
  logic [7:0] byte1_q, byte2_q;
  logic [7:0] cache_q;
  logic       cache_valid_q;

  logic       accept;
  logic [7:0] status_b, d1_b, d2_b, first_b, next1_b;
  logic [1:0] cnt_b;
  logic       skip_status;

  logic       tx_valid, tx_ready, byte_done;
  logic [7:0] tx_data;
  logic       unused_bits;

  assign unused_bits = &{1'b0, data1[7], data2[7]};

  assign accept = msg_valid & msg_ready;

  always_comb begin
    status_b    = {status_nibble(msg_type_t'(msg_type)), channel};
    d1_b        = {1'b0, data1[6:0]};
    d2_b        = {1'b0, data2[6:0]};
    skip_status = RUNNING_STATUS && cache_valid_q && (cache_q == status_b);
    first_b     = skip_status ? d1_b : status_b;
    next1_b     = skip_status ? d2_b : d1_b;
    cnt_b       = byte_count(msg_type_t'(msg_type)) - (skip_status ? 2'd1 : 2'd0);
  end

  // The first byte goes straight from the inputs to the serializer on the
  // acceptance cycle so the start bit appears on the very next cycle.
  always_comb begin
    state_nx = state;
    tx_valid = 1'b0;
    tx_data  = first_b;
    case (state)
      SEND: begin
        tx_valid = (byte_idx < byte_cnt);
        tx_data  = (byte_idx == 2'd1) ? byte1_q : byte2_q;
        if (byte_done && !tx_valid) state_nx = DONE;
      end
      default: begin // IDLE, DONE
        tx_valid = accept;
        state_nx = accept ? SEND : IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      msg_ready     <= 1'b0;
      busy          <= 1'b0;
      byte_idx      <= '0;
      byte_cnt      <= '0;
      byte1_q       <= '0;
      byte2_q       <= '0;
      cache_q       <= '0;
      cache_valid_q <= 1'b0;
    end else begin
      state     <= state_nx;
      msg_ready <= (state_nx != SEND);
      busy      <= (state_nx == SEND);
      if (accept) begin
        byte_idx <= 2'd1;
        byte_cnt <= cnt_b;
        byte1_q  <= next1_b;
        byte2_q  <= d2_b;
        if (RUNNING_STATUS && !skip_status) begin
          cache_q       <= status_b;
          cache_valid_q <= 1'b1;
        end
      end else if (tx_valid && tx_ready) begin
        byte_idx <= byte_idx + 2'd1;
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk       (clk),
    .reset     (reset),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .byte_done (byte_done),
    .tx        (midi_out)
  );

endmodule

// File: tb/tb_midi_transmitter.sv
// Bench for midi_transmitter: dut0 without and dut1 with running status,
// both at a short bit time. Expected byte streams come from a message-level
// model; the line is compared cycle by cycle against the expected frames.
module tb_midi_transmitter;

  localparam int unsigned CPB = 16;

  logic clk = 1'b0;
  logic reset;

  logic [1:0] msg_valid;
  logic [1:0] msg_type [2];
  logic [3:0] channel  [2];
  logic [7:0] data1    [2];
  logic [7:0] data2    [2];
  wire  [1:0] msg_ready;
  wire  [1:0] midi_out;
  wire  [1:0] busy;

  int checks = 0;
  int errors = 0;

  bit         cache_valid [2];
  logic [7:0] cache_val   [2];
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  midi_transmitter #(.CLKS_PER_BIT(CPB), .RUNNING_STATUS(1'b0)) dut0 (
    .clk(clk), .reset(reset), .msg_valid(msg_valid[0]), .msg_ready(msg_ready[0]),
    .msg_type(msg_type[0]), .channel(channel[0]), .data1(data1[0]), .data2(data2[0]),
    .midi_out(midi_out[0]), .busy(busy[0]));

  midi_transmitter #(.CLKS_PER_BIT(CPB), .RUNNING_STATUS(1'b1)) dut1 (
    .clk(clk), .reset(reset), .msg_valid(msg_valid[1]), .msg_ready(msg_ready[1]),
    .msg_type(msg_type[1]), .channel(channel[1]), .data1(data1[1]), .data2(data2[1]),
    .midi_out(midi_out[1]), .busy(busy[1]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Message-level reference: status byte (unless running status suppresses
  // it), masked data1, masked data2 except for program change.
  task automatic model_msg(input int d, input logic [1:0] ty, input logic [3:0] ch,
                           input logic [7:0] d1, input logic [7:0] d2);
    logic [7:0] st;
    case (ty)
      2'd0:    st = {4'h8, ch};
      2'd1:    st = {4'h9, ch};
      2'd2:    st = {4'hB, ch};
      default: st = {4'hC, ch};
    endcase
    exp_q.delete();
    if (!(d == 1 && cache_valid[d] && cache_val[d] == st)) begin
      exp_q.push_back(st);
      cache_valid[d] = 1'b1;
      cache_val[d]   = st;
    end
    exp_q.push_back(d1 & 8'h7F);
    if (ty != 2'd3) exp_q.push_back(d2 & 8'h7F);
  endtask

  task automatic drive_rand(input int d);
    msg_valid[d] = 1'b1;
    msg_type[d]  = 2'($urandom_range(0, 3));
    channel[d]   = 4'($urandom_range(0, 15));
    data1[d]     = 8'($urandom_range(0, 255));
    data2[d]     = 8'($urandom_range(0, 255));
  endtask

  // Called in a cycle where the DUT should be ready. With scramble set,
  // msg_valid stays high and inputs change every cycle of the message.
  task automatic run_msg(input int d, input logic [1:0] ty, input logic [3:0] ch,
                         input logic [7:0] d1, input logic [7:0] d2,
                         input bit scramble, input string name);
    logic [9:0] frame;
    int bad;
    int busy_bad;
    checks++;
    if (msg_ready[d] !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before: dut%0d msg_ready=%b expected 1", name, d, msg_ready[d]);
    end
    msg_valid[d] = 1'b1;
    msg_type[d]  = ty;
    channel[d]   = ch;
    data1[d]     = d1;
    data2[d]     = d2;
    model_msg(d, ty, ch, d1, d2);
    tick();
    if (!scramble) msg_valid[d] = 1'b0;
    checks++;
    if (busy[d] !== 1'b1 || msg_ready[d] !== 1'b0) begin
      errors++;
      $display("FAIL %s accept: dut%0d busy=%b msg_ready=%b expected busy=1 msg_ready=0",
               name, d, busy[d], msg_ready[d]);
    end
    busy_bad = 0;
    foreach (exp_q[i]) begin
      frame = {1'b1, exp_q[i], 1'b0};
      bad = 0;
      for (int j = 0; j < 10; j++) begin
        for (int c = 0; c < int'(CPB); c++) begin
          if (midi_out[d] !== frame[j]) bad++;
          if (busy[d] !== 1'b1) busy_bad++;
          if (scramble) drive_rand(d);
          tick();
        end
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL %s byte%0d: dut%0d %0d line cycles wrong, expected byte 0x%02h",
                 name, i, d, bad, exp_q[i]);
      end
    end
    checks++;
    if (busy_bad != 0) begin
      errors++;
      $display("FAIL %s busy_span: dut%0d busy low on %0d cycles, expected high for %0d cycles",
               name, d, busy_bad, exp_q.size() * 10 * CPB);
    end
    checks++;
    if (busy[d] !== 1'b0 || msg_ready[d] !== 1'b1 || midi_out[d] !== 1'b1) begin
      errors++;
      $display("FAIL %s end: dut%0d busy=%b msg_ready=%b midi_out=%b expected 0/1/1",
               name, d, busy[d], msg_ready[d], midi_out[d]);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    msg_valid = '0;
    for (int d = 0; d < 2; d++) begin
      msg_type[d] = '0; channel[d] = '0; data1[d] = '0; data2[d] = '0;
      cache_valid[d] = 1'b0; cache_val[d] = '0;
    end
    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (midi_out[d] !== 1'b1 || msg_ready[d] !== 1'b0 || busy[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state: dut%0d midi_out=%b msg_ready=%b busy=%b expected 1/0/0",
                 d, midi_out[d], msg_ready[d], busy[d]);
      end
    end
    reset = 1'b0;
    tick();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (msg_ready[d] !== 1'b1) begin
        errors++;
        $display("FAIL reset_release: dut%0d msg_ready=%b expected 1", d, msg_ready[d]);
      end
    end
  endtask

  task automatic test_idle();
    int bad [2];
    bad[0] = 0;
    bad[1] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int d = 0; d < 2; d++)
        if (midi_out[d] !== 1'b1 || busy[d] !== 1'b0) bad[d]++;
      tick();
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (bad[d] != 0) begin
        errors++;
        $display("FAIL idle_line: dut%0d %0d cycles not idle, expected 0", d, bad[d]);
      end
    end
  endtask

  task automatic test_note_on();
    run_msg(0, 2'd1, 4'd0, 8'd60, 8'd100, 1'b0, "note_on");
  endtask

  task automatic test_program_change();
    run_msg(0, 2'd3, 4'd15, 8'hFF, 8'h55, 1'b0, "program_change");
  endtask

  task automatic test_running_status();
    run_msg(1, 2'd1, 4'd3, 8'd60, 8'd100, 1'b0, "rs_first");
    run_msg(1, 2'd1, 4'd3, 8'd64, 8'd0,   1'b0, "rs_repeat");
    run_msg(1, 2'd2, 4'd3, 8'd7,  8'd127, 1'b0, "rs_cc");
    run_msg(1, 2'd2, 4'd3, 8'd9,  8'h80,  1'b0, "rs_cc_repeat");
  endtask

  task automatic test_random();
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 12; n++) begin
        run_msg(d, 2'($urandom_range(0, 3)), 4'($urandom_range(0, (d == 1) ? 1 : 15)),
                8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0, "random");
        for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 4; n++)
        run_msg(d, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 1)),
                8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1, "back_to_back");
      msg_valid[d] = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d1;
    int idx;
    int k;
    run_msg(1, 2'd1, 4'd5, 8'd33, 8'd44, 1'b0, "mid_prime");
    d1 = 8'($urandom_range(0, 255)) & 8'hEF; // bit 4 low so reset visibly lifts the line
    msg_valid[1] = 1'b1;
    msg_type[1]  = 2'd1;
    channel[1]   = 4'd5;
    data1[1]     = d1;
    data2[1]     = 8'd50;
    model_msg(1, 2'd1, 4'd5, d1, 8'd50);
    idx = (exp_q.size() == 3) ? 1 : 0;
    tick();
    msg_valid[1] = 1'b0;
    k = idx * 10 * int'(CPB) + 5 * int'(CPB) + int'(CPB) / 2;
    for (int c = 0; c < k; c++) tick();
    checks++;
    if (midi_out[1] !== 1'b0) begin
      errors++;
      $display("FAIL mid_bit4: midi_out=%b expected 0", midi_out[1]);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (midi_out[1] !== 1'b1 || busy[1] !== 1'b0 || msg_ready[1] !== 1'b0) begin
      errors++;
      $display("FAIL mid_async_reset: midi_out=%b busy=%b msg_ready=%b expected 1/0/0",
               midi_out[1], busy[1], msg_ready[1]);
    end
    cache_valid[0] = 1'b0;
    cache_valid[1] = 1'b0;
    tick();
    tick();
    checks++;
    if (midi_out[1] !== 1'b1 || busy[1] !== 1'b0 || msg_ready[1] !== 1'b0) begin
      errors++;
      $display("FAIL mid_hold_reset: midi_out=%b busy=%b msg_ready=%b expected 1/0/0",
               midi_out[1], busy[1], msg_ready[1]);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (msg_ready[1] !== 1'b1 || midi_out[1] !== 1'b1) begin
      errors++;
      $display("FAIL mid_release: msg_ready=%b midi_out=%b expected 1/1", msg_ready[1], midi_out[1]);
    end
    run_msg(1, 2'd1, 4'd5, 8'd33, 8'd44, 1'b0, "mid_resend");
  endtask

  initial begin
    test_reset();
    test_idle();
    test_note_on();
    test_program_change();
    test_running_status();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
